// File: rtl/avg_window_select.sv
// Sliding-window selector: picks the window sample closest to the window mean under a runtime rule.
// Latency: dout/dout_valid follow an accepted sample by one clock; throughput one sample per clock.
// Backpressure: none; din_valid qualifies input, output strobes only once the window is full.
module avg_window_select #(
    parameter int DW    = 16,
    parameter int DEPTH = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    input  logic [1:0]    mode,
    output logic          ready,
    output logic          dout_valid,
    output logic [DW-1:0] dout
);

    // Sum width covers DEPTH*(2^DW-1), so both the running sum and DEPTH*w fit exactly.
    localparam int SW = DW + $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CM1 = CW'(DEPTH - 1);

    // win[0] is the oldest sample, win[DEPTH-1] the newest.
    logic [DW-1:0] win [DEPTH];
    logic [SW-1:0] sum;
    logic [CW-1:0] count;
    logic          pend;     // an accepted sample with a full window awaits its output strobe
    logic          accept;
    logic          full_next;

    logic [SW-1:0] prod;
    logic [SW-1:0] diff;
    logic [SW-1:0] best_d;
    logic [DW-1:0] best_v;
    logic          found;
    logic          ok;
    logic          better;

    assign accept    = din_valid & ~clear;
    assign full_next = ready | (count == DEPTH_CM1);

    // Scan the window for the sample whose scaled value DEPTH*w lies closest to the sum (mean without divide).
    always_comb begin
        best_d = '0;
        best_v = '0;
        found  = 1'b0;
        prod   = '0;
        diff   = '0;
        ok     = 1'b0;
        better = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            prod = DEPTH_S * SW'(win[i]);
            diff = (prod >= sum) ? (prod - sum) : (sum - prod);
            case (mode)
                2'b01:   ok = (prod <= sum);
                2'b10:   ok = (prod >= sum);
                default: ok = 1'b1;
            endcase
            if (mode == 2'b11)
                better = (diff < best_d) || ((diff == best_d) && (win[i] > best_v));
            else
                better = (diff < best_d) || ((diff == best_d) && (win[i] < best_v));
            if (ok && (!found || better)) begin
                best_d = diff;
                best_v = win[i];
                found  = 1'b1;
            end
        end
    end

    // Window shift, running sum, fill tracking and the registered output strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum        <= '0;
            count      <= '0;
            ready      <= 1'b0;
            pend       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum        <= '0;
            count      <= '0;
            ready      <= 1'b0;
            pend       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            dout_valid <= pend;
            if (pend) dout <= best_v;
            pend <= accept & full_next;
            if (accept) begin
                for (int i = 0; i < DEPTH - 1; i++) win[i] <= win[i+1];
                win[DEPTH-1] <= din;
                // Modular arithmetic: the intermediate may wrap but the result is exact.
                sum <= sum - SW'(win[0]) + SW'(din);
                if (count != DEPTH_C) count <= count + 1'b1;
                if (count == DEPTH_CM1) ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avg_window_select.sv
// Bench for avg_window_select: directed scenarios plus randomized traffic against a queue-based model.
// Main instance DW=8/DEPTH=4; a second DW=16/DEPTH=12 instance covers the wide all-ones case.
module tb_avg_window_select;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        din_valid = 1'b0;
    logic [7:0]  din = '0;
    logic [1:0]  mode = '0;
    logic        ready;
    logic        dout_valid;
    logic [7:0]  dout;

    logic        b_clear = 1'b0;
    logic        b_valid = 1'b0;
    logic [15:0] b_din = '0;
    logic [1:0]  b_mode = '0;
    logic        b_ready;
    logic        b_dout_valid;
    logic [15:0] b_dout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int win_q[$];
    bit due;
    int exp_dout;
    bit exp_vld;
    bit exp_ready;

    always #5 clk = ~clk;

    avg_window_select #(.DW(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
        .mode(mode), .ready(ready), .dout_valid(dout_valid), .dout(dout)
    );

    avg_window_select #(.DW(16), .DEPTH(12)) dut_wide (
        .clk(clk), .reset(reset), .clear(b_clear), .din_valid(b_valid), .din(b_din),
        .mode(b_mode), .ready(b_ready), .dout_valid(b_dout_valid), .dout(b_dout)
    );

    // Closest-to-mean choice straight from the rules: |4*w - sum|, filtered and tie-broken by mode.
    function automatic int model_sel(int m);
        longint s = 0;
        longint d;
        longint best_d = 0;
        int best = -1;
        bit ok;
        foreach (win_q[i]) s += win_q[i];
        foreach (win_q[i]) begin
            longint p = 4 * longint'(win_q[i]);
            d  = (p > s) ? p - s : s - p;
            ok = (m == 0) || (m == 3) || (m == 1 && p <= s) || (m == 2 && p >= s);
            if (ok) begin
                if (best < 0 || d < best_d ||
                    (d == best_d && ((m == 3) ? (win_q[i] > best) : (win_q[i] < best)))) begin
                    best   = win_q[i];
                    best_d = d;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        win_q.delete();
        due = 0; exp_dout = 0; exp_vld = 0; exp_ready = 0;
    endtask

    task automatic model_step(bit v, int d, int m, bit c);
        if (c) begin
            model_reset();
        end else begin
            exp_vld = due;
            if (due) exp_dout = model_sel(m);
            if (v) begin
                win_q.push_back(d);
                if (win_q.size() > 4) void'(win_q.pop_front());
            end
            exp_ready = (win_q.size() == 4);
            due = v && exp_ready;
        end
    endtask

    // Drive one cycle on the main instance and advance the model; returns at posedge+1.
    task automatic tick(bit v, int d, int m, bit c);
        din_valid = v; din = 8'(d); mode = 2'(m); clear = c;
        @(posedge clk);
        #1;
        model_step(v, d, m, c);
    endtask

    task automatic fill4(int a, int b, int c, int d);
        tick(0, 0, 0, 1);
        tick(1, a, 0, 0);
        tick(1, b, 0, 0);
        tick(1, c, 0, 0);
        tick(1, d, 0, 0);
    endtask

    task automatic test_reset();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b expected 0", ready); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0b expected 0", dout_valid); end
        n_cmp++; if (dout !== 8'd0) begin n_err++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        n_cmp++; if ({b_ready, b_dout_valid, b_dout} !== 18'd0) begin n_err++; $display("FAIL reset_wide: got %0h expected 0", {b_ready, b_dout_valid, b_dout}); end
    endtask

    task automatic test_fill();
        int lit[3] = '{3, 3, 10};
        for (int m = 0; m < 3; m++) begin
            tick(0, 0, 0, 1);
            tick(1, 1, 0, 0);
            tick(1, 2, 0, 0);
            tick(1, 3, 0, 0);
            n_cmp++; if (ready !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL fill_3rd: ready %0b vld %0b expected 0 0", ready, dout_valid); end
            tick(1, 10, 0, 0);
            n_cmp++; if (ready !== 1'b1 || dout_valid !== 1'b0) begin n_err++; $display("FAIL fill_4th: ready %0b vld %0b expected 1 0", ready, dout_valid); end
            tick(0, 0, m, 0);
            n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'(lit[m])) begin n_err++; $display("FAIL fill_mode%0d: vld %0b dout %0d expected 1 %0d", m, dout_valid, dout, lit[m]); end
        end
    endtask

    task automatic test_slide();
        int modes[2] = '{0, 2};
        int lit[2] = '{3, 10};
        for (int k = 0; k < 2; k++) begin
            fill4(1, 2, 3, 10);
            tick(1, 10, 0, 0);
            n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'd3) begin n_err++; $display("FAIL slide_prev: vld %0b dout %0d expected 1 3", dout_valid, dout); end
            tick(0, 0, modes[k], 0);
            n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'(lit[k])) begin n_err++; $display("FAIL slide_mode%0d: vld %0b dout %0d expected 1 %0d", modes[k], dout_valid, dout, lit[k]); end
        end
    endtask

    task automatic test_ties();
        int lit[4] = '{2, 2, 6, 6};
        for (int m = 0; m < 4; m++) begin
            fill4(2, 6, 2, 6);
            tick(0, 0, m, 0);
            n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'(lit[m])) begin n_err++; $display("FAIL tie_mode%0d: vld %0b dout %0d expected 1 %0d", m, dout_valid, dout, lit[m]); end
        end
    endtask

    task automatic test_gap();
        fill4(1, 2, 3, 10);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, $urandom_range(0, 255), $urandom_range(0, 3), 0);
            n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'd3 || ready !== 1'b1) begin n_err++; $display("FAIL gap_%0d: vld %0b dout %0d ready %0b expected 0 3 1", i, dout_valid, dout, ready); end
        end
    endtask

    task automatic test_limits();
        fill4(255, 255, 255, 255);
        tick(0, 0, 0, 0);
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'd255) begin n_err++; $display("FAIL max8: vld %0b dout %0d expected 1 255", dout_valid, dout); end
    endtask

    task automatic test_wide();
        b_clear = 1'b1; tick(0, 0, 0, 0); b_clear = 1'b0;
        b_valid = 1'b1; b_din = 16'hFFFF; b_mode = 2'd0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0);
            if (i == 10) begin
                n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL wide_ready11: got %0b expected 0", b_ready); end
            end
        end
        n_cmp++; if (b_ready !== 1'b1 || b_dout_valid !== 1'b0) begin n_err++; $display("FAIL wide_full: ready %0b vld %0b expected 1 0", b_ready, b_dout_valid); end
        b_valid = 1'b0;
        tick(0, 0, 0, 0);
        n_cmp++; if (b_dout_valid !== 1'b1 || b_dout !== 16'hFFFF) begin n_err++; $display("FAIL wide_max: vld %0b dout %0h expected 1 ffff", b_dout_valid, b_dout); end
    endtask

    task automatic test_back_to_back();
        tick(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1, $urandom_range(0, 255), $urandom_range(0, 3), 0);
            n_cmp++; if (dout_valid !== exp_vld || dout !== 8'(exp_dout)) begin n_err++; $display("FAIL b2b_%0d: vld %0b dout %0d expected %0b %0d", i, dout_valid, dout, exp_vld, exp_dout); end
        end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_strobe: got %0b expected 1", dout_valid); end
    endtask

    task automatic test_clear();
        fill4(5, 9, 14, 20);
        tick(1, 7, 1, 0);
        tick(1, 30, 2, 0);
        tick(1, 77, 0, 1);
        n_cmp++; if (ready !== 1'b0 || dout_valid !== 1'b0 || dout !== 8'd0) begin n_err++; $display("FAIL clear_out: ready %0b vld %0b dout %0d expected 0 0 0", ready, dout_valid, dout); end
        for (int i = 0; i < 4; i++) begin
            tick(1, $urandom_range(0, 255), 0, 0);
            n_cmp++; if (dout_valid !== 1'b0 || ready !== (i == 3)) begin n_err++; $display("FAIL clear_refill_%0d: vld %0b ready %0b expected 0 %0b", i, dout_valid, ready, i == 3); end
        end
        tick(0, 0, 3, 0);
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'(exp_dout)) begin n_err++; $display("FAIL clear_first_strobe: vld %0b dout %0d expected 1 %0d", dout_valid, dout, exp_dout); end
    endtask

    task automatic test_reset_mid();
        fill4(40, 50, 60, 70);
        tick(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({ready, dout_valid, dout} !== 10'd0) begin n_err++; $display("FAIL async_reset: ready %0b vld %0b dout %0d expected 0 0 0", ready, dout_valid, dout); end
        #1 reset = 1'b0;
        model_reset();
        tick(1, 1, 0, 0);
        n_cmp++; if (ready !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_refill: ready %0b vld %0b expected 0 0", ready, dout_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v = ($urandom_range(0, 9) < 7);
            int d = $urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            bit c = ($urandom_range(0, 39) == 0);
            tick(v, d, $urandom_range(0, 3), c);
            n_cmp++; if (dout_valid !== exp_vld || ready !== exp_ready || dout !== 8'(exp_dout)) begin
                n_err++;
                $display("FAIL rand_%0d: vld %0b ready %0b dout %0d expected %0b %0b %0d", i, dout_valid, ready, dout, exp_vld, exp_ready, exp_dout);
            end
        end
    endtask

    initial begin
        model_reset();
        #12 reset = 1'b0;
        test_reset();
        test_fill();
        test_slide();
        test_ties();
        test_gap();
        test_limits();
        test_wide();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
